fp_iterative_divider: RTL and testbench

- Single-precision IEEE-754 divider for FDIV.S. It is the inverse companion to the pipelined FP multiplier in the FP execute cluster.
- Iterative radix-2 restoring division over a start/done handshake.
- Carries a destination tag alongside the operation, so writeback can steer the result.
- Shares the multiplier's en (stall) and clear (flush) semantics.

---
 rtl/fp_pkg.sv | 35 +++
 rtl/fp_iterative_divider_if.sv | 26 ++
 rtl/fp_lzc24.sv | 12 +
 rtl/fp_iterative_divider.sv | 220 ++++++++++++++++++++++
 tb/tb_fp_iterative_divider.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared FP execute-cluster types: rounding modes, flag indices,
// the fp32 field view and the divider state encoding.
package fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  localparam int FF_NX = 0;
  localparam int FF_UF = 1;
  localparam int FF_OF = 2;
  localparam int FF_DZ = 3;
  localparam int FF_NV = 4;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_DIV   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } div_state_e;

endpackage

// File: rtl/fp_iterative_divider_if.sv
// Start/done bundle between the FP issue logic
// and the iterative divider.
interface fp_iterative_divider_if #(
  parameter int TAG_W = 7
);
  logic             start;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [2:0]       rm;
  logic [TAG_W-1:0] tag_i;
  logic             busy;
  logic             done;
  logic [31:0]      result;
  logic [4:0]       fflags;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output start, a, b, rm, tag_i,
    input  busy, done, result, fflags, tag_o
  );

  modport slave (
    input  start, a, b, rm, tag_i,
    output busy, done, result, fflags, tag_o
  );
endinterface

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter; returns 24 for an all-zero input.
// Shared by the divider and a future square-root unit.
module fp_lzc24 (
  input  logic [23:0] x,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++)
      if (x[i]) cnt = 5'(23 - i);
  end
endmodule

// File: rtl/fp_iterative_divider.sv
// FDIV.S: radix-2 restoring divider, one quotient bit per cycle,
// with a pass-through writeback tag.
module fp_iterative_divider
  import fp_pkg::*;
#(
  parameter int TAG_W = 7,
  parameter int QBITS = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  fp_iterative_divider_if.slave io
);
  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] PREP  = S_PREP;
  localparam logic [2:0] DIV   = S_DIV;
  localparam logic [2:0] ROUND = S_ROUND;
  localparam logic [2:0] DONE  = S_DONE;

  logic [2:0]        state;
  fp32_t             ua, ub;
  logic [2:0]        rm_r;
  logic [TAG_W-1:0]  tag_r, tag_q;
  logic              sign_r;
  logic signed [9:0] exp_r;
  logic [23:0]       mb_r;
  logic [QBITS-1:0]  r_r, q_r;
  logic [4:0]        cnt;
  logic [31:0]       res_q;
  logic [4:0]        flg_q;

  logic [23:0] sig_a, sig_b, ma_n, mb_n;
  logic [4:0]  lz_a, lz_b;

  assign sig_a = {|ua.exp, ua.man};
  assign sig_b = {|ub.exp, ub.man};

  fp_lzc24 u_lzc_a (.x(sig_a), .cnt(lz_a));
  fp_lzc24 u_lzc_b (.x(sig_b), .cnt(lz_b));

  assign ma_n = sig_a << lz_a;
  assign mb_n = sig_b << lz_b;

  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;
  assign a_zero = ~|ua.exp & ~|ua.man;
  assign b_zero = ~|ub.exp & ~|ub.man;
  assign a_inf  = &ua.exp & ~|ua.man;
  assign b_inf  = &ub.exp & ~|ub.man;
  assign a_nan  = &ua.exp & |ua.man;
  assign b_nan  = &ub.exp & |ub.man;
  assign a_snan = a_nan & ~ua.man[22];
  assign b_snan = b_nan & ~ub.man[22];

  // Subnormals act as exponent 1 minus their normalizing shift.
  logic signed [9:0] ea, eb, exp_pre;
  logic              sign_pre;
  assign ea = (ua.exp == 8'd0 ? 10'sd1 : $signed({2'b00, ua.exp}))
            - $signed({5'b00000, lz_a});
  assign eb = (ub.exp == 8'd0 ? 10'sd1 : $signed({2'b00, ub.exp}))
            - $signed({5'b00000, lz_b});
  assign exp_pre  = ea - eb + 10'sd127;
  assign sign_pre = ua.sign ^ ub.sign;

  logic        sp_hit;
  logic [31:0] sp_res;
  logic [4:0]  sp_flg;

  always_comb begin
    sp_hit = 1'b1;
    sp_res = CANON_NAN;
    sp_flg = '0;
    if (a_snan | b_snan) begin
      sp_flg[FF_NV] = 1'b1;
    end else if (a_nan | b_nan) begin
      sp_flg = '0;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      sp_flg[FF_NV] = 1'b1;
    end else if (a_inf) begin
      sp_res = {sign_pre, 8'hFF, 23'd0};
    end else if (b_zero) begin
      sp_res = {sign_pre, 8'hFF, 23'd0};
      sp_flg[FF_DZ] = 1'b1;
    end else if (b_inf | a_zero) begin
      sp_res = {sign_pre, 31'd0};
    end else begin
      sp_hit = 1'b0;
    end
  end

  logic [QBITS-1:0] mb_ext, r_sub;
  logic             r_ge;
  assign mb_ext = QBITS'(mb_r);
  assign r_ge   = r_r >= mb_ext;
  assign r_sub  = r_r - mb_ext;

  logic [QBITS-1:0]  qn, m, lost_mask;
  logic signed [9:0] en_exp, sh_raw;
  logic              tiny_pre, lost, g, st, nx, inc, to_inf, ovf;
  logic [4:0]        sh;
  logic [9:0]        e_base;
  logic [32:0]       sum;

  assign qn       = q_r[QBITS-1] ? q_r : {q_r[QBITS-2:0], 1'b0};
  assign en_exp   = q_r[QBITS-1] ? exp_r : exp_r - 10'sd1;
  assign tiny_pre = en_exp <= 10'sd0;
  assign sh_raw   = 10'sd1 - en_exp;
  assign sh = !tiny_pre ? 5'd0 :
              (sh_raw > $signed(10'(QBITS)) ? 5'(QBITS) : sh_raw[4:0]);

  assign m         = qn >> sh;
  assign lost_mask = ~({QBITS{1'b1}} << sh);
  assign lost      = |(qn & lost_mask);
  assign g         = m[QBITS-25];
  assign st        = lost | (|r_r) | (|m[QBITS-26:0]);
  assign nx        = g | st;

  always_comb begin
    unique case (rm_r)
      RM_RTZ:  begin inc = 1'b0;          to_inf = 1'b0;    end
      RM_RDN:  begin inc = sign_r & nx;   to_inf = sign_r;  end
      RM_RUP:  begin inc = ~sign_r & nx;  to_inf = ~sign_r; end
      RM_RMM:  begin inc = g;             to_inf = 1'b1;    end
      default: begin
        inc    = g & (st | m[QBITS-24]);
        to_inf = 1'b1;
      end
    endcase
  end

  // The hidden bit of the 24-bit significand carries into the
  // exponent field, so normals use exp-1 as base and subnormals 0.
  assign e_base = tiny_pre ? 10'd0 : $unsigned(en_exp - 10'sd1);
  assign sum = {e_base, 23'd0} + 33'(m[QBITS-1:2]) + 33'(inc);
  assign ovf = sum[32:23] >= 10'd255;

  logic [31:0] rnd_res;
  logic [4:0]  rnd_flg;

  always_comb begin
    rnd_flg = '0;
    if (ovf)
      rnd_res = to_inf ? {sign_r, 8'hFF, 23'd0}
                       : {sign_r, 31'h7F7F_FFFF};
    else
      rnd_res = {sign_r, sum[30:0]};
    rnd_flg[FF_OF] = ovf;
    rnd_flg[FF_UF] = ~ovf & nx & (sum[30:23] == 8'd0);
    rnd_flg[FF_NX] = nx | ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ua     <= '0;
      ub     <= '0;
      rm_r   <= '0;
      tag_r  <= '0;
      tag_q  <= '0;
      sign_r <= 1'b0;
      exp_r  <= '0;
      mb_r   <= '0;
      r_r    <= '0;
      q_r    <= '0;
      cnt    <= '0;
      res_q  <= '0;
      flg_q  <= '0;
    end else if (clear) begin
      state <= IDLE;
    end else if (en) begin
      case (state)
        IDLE: if (io.start) begin
          ua    <= io.a;
          ub    <= io.b;
          rm_r  <= io.rm;
          tag_r <= io.tag_i;
          state <= PREP;
        end
        PREP: begin
          sign_r <= sign_pre;
          exp_r  <= exp_pre;
          mb_r   <= mb_n;
          r_r    <= QBITS'(ma_n);
          q_r    <= '0;
          cnt    <= 5'(QBITS - 1);
          if (sp_hit) begin
            res_q <= sp_res;
            flg_q <= sp_flg;
            tag_q <= tag_r;
            state <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          q_r <= {q_r[QBITS-2:0], r_ge};
          r_r <= (r_ge ? r_sub : r_r) << 1;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= ROUND;
        end
        ROUND: begin
          res_q <= rnd_res;
          flg_q <= rnd_flg;
          tag_q <= tag_r;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy   = state != IDLE;
  assign io.done   = state == DONE;
  assign io.result = res_q;
  assign io.fflags = flg_q;
  assign io.tag_o  = tag_q;

endmodule

// File: tb/tb_fp_iterative_divider.sv
// Directed-vector bench for fp_iterative_divider: results, flags,
// latency and the en/clear/rst/busy-start controls.
module tb_fp_iterative_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic clear = 1'b0;

  fp_iterative_divider_if #(.TAG_W(7)) io ();

  fp_iterative_divider #(.TAG_W(7), .QBITS(26)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clear(clear),
    .io(io)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;

  localparam logic [4:0] F_NV = 5'b10000;
  localparam logic [4:0] F_DZ = 5'b01000;
  localparam logic [4:0] F_OF = 5'b00100;
  localparam logic [4:0] F_UF = 5'b00010;
  localparam logic [4:0] F_NX = 5'b00001;

  int n_tests = 0;
  int n_fail = 0;

  int en_lo = -1;
  int en_hi = -1;
  int dup_at = -1;

  logic [31:0] o_res;
  logic [4:0]  o_flg;
  logic [6:0]  o_tag;
  int          o_cyc;
  int          busy_bad;
  logic        o_done_next;
  logic        o_busy_next;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is high in cycle 0; o_cyc is the cycle in which done is seen.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] rm, input logic [6:0] tg);
    io.a = a;
    io.b = b;
    io.rm = rm;
    io.tag_i = tg;
    io.start = 1'b1;
    o_cyc = -1;
    busy_bad = 0;
    tick();
    io.start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (io.busy !== 1'b1) busy_bad++;
      if (io.done === 1'b1) begin
        o_cyc = c;
        break;
      end
      en = !(c >= en_lo && c <= en_hi);
      if (c == dup_at) begin
        io.start = 1'b1;
        io.a = 32'h3F80_0000;
        io.b = 32'h4040_0000;
        io.tag_i = 7'h7F;
      end
      tick();
      io.start = 1'b0;
      en = 1'b1;
    end
    o_res = io.result;
    o_flg = io.fflags;
    o_tag = io.tag_o;
    tick();
    o_done_next = io.done;
    o_busy_next = io.busy;
  endtask

  task automatic chk_op(input string name, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] rm,
                        input logic [31:0] exp_res,
                        input logic [4:0] exp_flg, input int exp_cyc);
    run(a, b, rm, 7'h15);
    chk({name, " res"}, o_res, exp_res);
    chk({name, " flg"}, 32'(o_flg), 32'(exp_flg));
    chk({name, " cyc"}, 32'(o_cyc), 32'(exp_cyc));
  endtask

  initial begin
    io.start = 1'b0;
    io.a = '0;
    io.b = '0;
    io.rm = '0;
    io.tag_i = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst busy", 32'(io.busy), 32'd0);
    chk("rst done", 32'(io.done), 32'd0);
    chk("rst result", io.result, 32'd0);
    chk("rst fflags", 32'(io.fflags), 32'd0);
    chk("rst tag", 32'(io.tag_o), 32'd0);

    run(32'h40C0_0000, 32'h4000_0000, RNE, 7'h2B);
    chk("6/2 res", o_res, 32'h4040_0000);
    chk("6/2 flg", 32'(o_flg), 32'd0);
    chk("6/2 cyc", 32'(o_cyc), 32'd29);
    chk("6/2 busy", 32'(busy_bad), 32'd0);
    chk("6/2 tag", 32'(o_tag), 32'h2B);
    chk("6/2 pulse", 32'(o_done_next), 32'd0);
    chk("6/2 idle", 32'(o_busy_next), 32'd0);

    chk_op("1/3 rne", 32'h3F80_0000, 32'h4040_0000, RNE,
           32'h3EAA_AAAB, F_NX, 29);
    chk_op("1/3 rtz", 32'h3F80_0000, 32'h4040_0000, RTZ,
           32'h3EAA_AAAA, F_NX, 29);
    chk_op("1/3 rup", 32'h3F80_0000, 32'h4040_0000, RUP,
           32'h3EAA_AAAB, F_NX, 29);
    chk_op("1/3 rdn", 32'h3F80_0000, 32'h4040_0000, RDN,
           32'h3EAA_AAAA, F_NX, 29);
    chk_op("-1/3 rdn", 32'hBF80_0000, 32'h4040_0000, RDN,
           32'hBEAA_AAAB, F_NX, 29);

    chk_op("1/0", 32'h3F80_0000, 32'h0000_0000, RNE,
           32'h7F80_0000, F_DZ, 2);
    chk_op("-0/0", 32'h8000_0000, 32'h0000_0000, RNE,
           32'h7FC0_0000, F_NV, 2);
    chk_op("snan", 32'h7F80_0001, 32'h3F80_0000, RNE,
           32'h7FC0_0000, F_NV, 2);
    chk_op("qnan", 32'h7FC0_0000, 32'h4000_0000, RNE,
           32'h7FC0_0000, 5'd0, 2);
    chk_op("inf/inf", 32'h7F80_0000, 32'hFF80_0000, RNE,
           32'h7FC0_0000, F_NV, 2);
    chk_op("-inf/2", 32'hFF80_0000, 32'h4000_0000, RNE,
           32'hFF80_0000, 5'd0, 2);
    chk_op("2/-inf", 32'h4000_0000, 32'hFF80_0000, RNE,
           32'h8000_0000, 5'd0, 2);

    chk_op("ovf rne", 32'h7F7F_FFFF, 32'h3F00_0000, RNE,
           32'h7F80_0000, F_OF | F_NX, 29);
    chk_op("ovf rtz", 32'h7F7F_FFFF, 32'h3F00_0000, RTZ,
           32'h7F7F_FFFF, F_OF | F_NX, 29);

    chk_op("sub half", 32'h0080_0000, 32'h4000_0000, RNE,
           32'h0040_0000, 5'd0, 29);
    chk_op("tiny rne", 32'h0000_0001, 32'h4000_0000, RNE,
           32'h0000_0000, F_UF | F_NX, 29);
    chk_op("tiny rup", 32'h0000_0001, 32'h4000_0000, RUP,
           32'h0000_0001, F_UF | F_NX, 29);
    chk_op("sub/sub", 32'h0000_0001, 32'h0000_0001, RNE,
           32'h3F80_0000, 5'd0, 29);

    // Flush at cycle 10, then a fresh op started in cycle 12.
    io.a = 32'h3F80_0000;
    io.b = 32'h4040_0000;
    io.rm = RNE;
    io.tag_i = 7'h11;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    repeat (9) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr busy", 32'(io.busy), 32'd0);
    chk("clr done", 32'(io.done), 32'd0);
    tick();
    run(32'h40C0_0000, 32'h4000_0000, RNE, 7'h2A);
    chk("clr res", o_res, 32'h4040_0000);
    chk("clr cyc", 32'(12 + o_cyc), 32'd41);
    chk("clr tag", 32'(o_tag), 32'h2A);

    en_lo = 5;
    en_hi = 9;
    run(32'h40C0_0000, 32'h4000_0000, RNE, 7'h33);
    en_lo = -1;
    en_hi = -1;
    chk("stall cyc", 32'(o_cyc), 32'd34);
    chk("stall res", o_res, 32'h4040_0000);

    dup_at = 5;
    run(32'h40C0_0000, 32'h4000_0000, RNE, 7'h44);
    dup_at = -1;
    chk("dup res", o_res, 32'h4040_0000);
    chk("dup tag", 32'(o_tag), 32'h44);
    chk("dup cyc", 32'(o_cyc), 32'd29);
    chk("dup idle", 32'(o_busy_next), 32'd0);

    io.a = 32'h40C0_0000;
    io.b = 32'h4000_0000;
    io.tag_i = 7'h05;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst busy", 32'(io.busy), 32'd0);
    chk("mid rst done", 32'(io.done), 32'd0);
    chk("mid rst res", io.result, 32'd0);
    chk("mid rst flg", 32'(io.fflags), 32'd0);
    chk("mid rst tag", 32'(io.tag_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
